// File: rtl/datapath_sequencer_if.sv
// Instruction-memory fetch port of the datapath sequencer.
//   imem_req   sequencer -> memory  fetch request, held until imem_ack
//   imem_addr  sequencer -> memory  fetch address (the current PC)
//   imem_ack   memory -> sequencer  fetch complete, imem_data valid this cycle
//   imem_data  memory -> sequencer  32-bit instruction word
// master = sequencer side, slave = instruction-memory side.
interface datapath_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle FETCH -> DECODE -> EXEC controller for the single-cycle
// register/ALU/data-memory datapath (MIPS subset). Owns the PC, fetches over
// a req/ack instruction port, drives all datapath fields and controls, and
// resolves beq/bne from the datapath zero flag.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   imem            fetch port (datapath_sequencer_if.master)
//   zero, ovflw     datapath ALU flags
//   rd rt rs shamt  5-bit instruction fields
//   imm             16-bit immediate field
//   reg_wr mem_wr   write strobes, high only during EXEC
//   reg_dst alu_src ext_op mem_to_reg alu_ctrl   datapath controls
//   pc              current PC (also the fetch address)
//   halted          sequencer stopped; cleared only by rst
//
// Build option: DATAPATH_SEQ_OVF_TRAP_EN -- when defined, add/sub/addi with
// ovflw=1 suppress reg_wr, keep the PC and stop in HALT.
module datapath_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic                         clk,
    input  logic                         rst,
    datapath_sequencer_if.master         imem,
    input  logic                         zero,
    input  logic                         ovflw,
    output logic [4:0]                   rd,
    output logic [4:0]                   rt,
    output logic [4:0]                   rs,
    output logic [4:0]                   shamt,
    output logic [15:0]                  imm,
    output logic                         reg_wr,
    output logic                         reg_dst,
    output logic                         alu_src,
    output logic                         ext_op,
    output logic                         mem_wr,
    output logic                         mem_to_reg,
    output logic [2:0]                   alu_ctrl,
    output logic [31:0]                  pc,
    output logic                         halted
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
    typedef enum logic [1:0] {PC_SEQ, PC_BEQ, PC_BNE, PC_JMP} pc_sel_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    state_t      r_state;
    pc_sel_t     r_pc_sel;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_imem_req;
    logic [4:0]  r_rd, r_rt, r_rs, r_shamt;
    logic [15:0] r_imm;
    logic        r_reg_wr, r_mem_wr, r_reg_dst, r_alu_src, r_ext_op, r_mem_to_reg;
    logic [2:0]  r_alu_ctrl;
    logic        r_halted;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_valid;
    logic        w_reg_dst, w_alu_src, w_ext_op, w_mem_to_reg, w_reg_wr, w_mem_wr;
    logic [2:0]  w_alu_ctrl;
    pc_sel_t     w_pc_sel;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_pc_next;
    logic        w_trap;

    assign w_op    = r_ir[31:26];
    assign w_funct = r_ir[5:0];

    // Decode of the latched instruction; consumed only in DECODE.
    always_comb begin
        w_valid      = 1'b1;
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_ext_op     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_wr     = 1'b0;
        w_mem_wr     = 1'b0;
        w_alu_ctrl   = ALU_ADD;
        w_pc_sel     = PC_SEQ;
        if (w_op == HALT_OPCODE) begin
            w_valid = 1'b0;
        end else begin
            case (w_op)
                OP_RTYPE: begin
                    w_reg_dst = 1'b1;
                    w_reg_wr  = 1'b1;
                    case (w_funct)
                        FN_ADD:  w_alu_ctrl = ALU_ADD;
                        FN_SUB:  w_alu_ctrl = ALU_SUB;
                        FN_AND:  w_alu_ctrl = ALU_AND;
                        FN_OR:   w_alu_ctrl = ALU_OR;
                        FN_SLT:  w_alu_ctrl = ALU_SLT;
                        FN_SLL:  w_alu_ctrl = ALU_SLL;
                        default: w_valid    = 1'b0;
                    endcase
                end
                OP_ADDI: begin
                    w_alu_src = 1'b1;
                    w_ext_op  = 1'b1;
                    w_reg_wr  = 1'b1;
                end
                OP_ORI: begin
                    w_alu_src  = 1'b1;
                    w_alu_ctrl = ALU_OR;
                    w_reg_wr   = 1'b1;
                end
                OP_LW: begin
                    w_alu_src    = 1'b1;
                    w_ext_op     = 1'b1;
                    w_mem_to_reg = 1'b1;
                    w_reg_wr     = 1'b1;
                end
                OP_SW: begin
                    w_alu_src = 1'b1;
                    w_ext_op  = 1'b1;
                    w_mem_wr  = 1'b1;
                end
                OP_BEQ: begin
                    w_alu_ctrl = ALU_SUB;
                    w_pc_sel   = PC_BEQ;
                end
                OP_BNE: begin
                    w_alu_ctrl = ALU_SUB;
                    w_pc_sel   = PC_BNE;
                end
                OP_J:    w_pc_sel = PC_JMP;
                default: w_valid  = 1'b0;
            endcase
        end
    end

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_imm[15]}}, r_imm, 2'b00};

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (r_pc_sel)
            PC_BEQ:  if (zero)  w_pc_next = w_pc_plus4 + w_br_off;
            PC_BNE:  if (!zero) w_pc_next = w_pc_plus4 + w_br_off;
            PC_JMP:  w_pc_next = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
            default: w_pc_next = w_pc_plus4;
        endcase
    end

`ifdef DATAPATH_SEQ_OVF_TRAP_EN
    logic r_ovf_chk;

    // r_ovf_chk is only meaningful while r_reg_wr is high, i.e. in EXEC.
    assign w_trap = r_ovf_chk & ovflw;
`else
    logic w_unused_ovflw;

    assign w_trap         = 1'b0;
    assign w_unused_ovflw = ovflw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc_sel     <= PC_SEQ;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_imem_req   <= 1'b0;
            r_rd         <= '0;
            r_rt         <= '0;
            r_rs         <= '0;
            r_shamt      <= '0;
            r_imm        <= '0;
            r_reg_wr     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_alu_src    <= 1'b0;
            r_ext_op     <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_ctrl   <= '0;
            r_halted     <= 1'b0;
`ifdef DATAPATH_SEQ_OVF_TRAP_EN
            r_ovf_chk    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    // Accept only while the request is actually on the bus;
                    // the first FETCH cycle after reset raises the request.
                    if (r_imem_req && imem.imem_ack) begin
                        r_ir       <= imem.imem_data;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_rs         <= r_ir[25:21];
                    r_rt         <= r_ir[20:16];
                    r_rd         <= r_ir[15:11];
                    r_shamt      <= r_ir[10:6];
                    r_imm        <= r_ir[15:0];
                    r_reg_dst    <= w_reg_dst;
                    r_alu_src    <= w_alu_src;
                    r_ext_op     <= w_ext_op;
                    r_mem_to_reg <= w_mem_to_reg;
                    r_alu_ctrl   <= w_alu_ctrl;
                    r_pc_sel     <= w_pc_sel;
`ifdef DATAPATH_SEQ_OVF_TRAP_EN
                    r_ovf_chk    <= ((w_op == OP_RTYPE) &&
                                     ((w_funct == FN_ADD) || (w_funct == FN_SUB))) ||
                                    (w_op == OP_ADDI);
`endif
                    if (w_valid) begin
                        r_reg_wr <= w_reg_wr;
                        r_mem_wr <= w_mem_wr;
                        r_state  <= S_EXEC;
                    end else begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end
                end
                S_EXEC: begin
                    r_reg_wr <= 1'b0;
                    r_mem_wr <= 1'b0;
                    if (w_trap) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_pc       <= w_pc_next;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_halted   <= 1'b1;
                    r_imem_req <= 1'b0;
                    r_reg_wr   <= 1'b0;
                    r_mem_wr   <= 1'b0;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_pc;
    assign pc             = r_pc;
    assign rd             = r_rd;
    assign rt             = r_rt;
    assign rs             = r_rs;
    assign shamt          = r_shamt;
    assign imm            = r_imm;
    assign reg_wr         = r_reg_wr & ~w_trap;
    assign mem_wr         = r_mem_wr;
    assign reg_dst        = r_reg_dst;
    assign alu_src        = r_alu_src;
    assign ext_op         = r_ext_op;
    assign mem_to_reg     = r_mem_to_reg;
    assign alu_ctrl       = r_alu_ctrl;
    assign halted         = r_halted;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle control unit that sequences the single-cycle register/ALU/data-memory datapath.
- Owns the PC and fetches 32-bit MIPS-subset instructions over a req/ack instruction-memory port.
- Decodes each instruction and drives every datapath control and field input: rd, rt, rs, shamt, imm, reg_wr, reg_dst, alu_src, ext_op, alu_ctrl, mem_wr, mem_to_reg.
- Resolves branches from the datapath zero flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, opcode that stops the sequencer.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address; equals pc.
- imem_ack  input  1  fetch complete; imem_data valid this cycle.
- imem_data  input  32  instruction word.
- zero  input  1  datapath ALU zero flag.
- ovflw  input  1  datapath ALU signed-overflow flag.
- rd, rt, rs, shamt  output  5 each  instruction fields to the datapath.
- imm  output  16  immediate field.
- reg_wr, reg_dst, alu_src, ext_op, mem_wr, mem_to_reg  output  1 each  datapath controls.
- alu_ctrl  output  3  ALU operation.
- pc  output  32  current PC.
- halted  output  1  sequencer stopped.

Behaviour:
- States: FETCH, DECODE, EXEC, HALT.
- Reset (asynchronous, any state, including mid-fetch or mid-EXEC):
  - state=FETCH, pc=RESET_PC, instruction register=0.
  - All field and control outputs 0; halted=0.
  - imem_req is 0 during reset and rises on the first clk edge after rst deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On a clk edge with imem_ack=1: latch imem_data, go to DECODE. imem_req=0 from the next cycle.
  - imem_ack outside FETCH is ignored.
- DECODE:
  - Register the decoded fields and controls: reg_dst, alu_src, ext_op, mem_to_reg, alu_ctrl, rd/rt/rs/shamt/imm.
  - Opcode equal to HALT_OPCODE or unsupported -> HALT; otherwise -> EXEC.
- EXEC (exactly one cycle):
  - reg_wr and mem_wr are asserted only in EXEC; the datapath commits on the clk edge that leaves EXEC.
  - PC update on that edge:
    - pc+4 by default.
    - beq with zero=1, or bne with zero=0: pc+4+(sext(imm)<<2).
    - j: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Next state is FETCH.
- Non-EXEC states: reg_wr=mem_wr=0; the other outputs hold their registered values.
- HALT: absorbing state, halted=1, imem_req=0, all writes 0. Left only through rst.
- Latency: 3 cycles per instruction plus imem wait cycles. With zero-wait ack, throughput is 1 instruction per 3 cycles.
- ALU encoding: ADD 000, SUB 001, AND 010, OR 011, SLT 100, SLL 101.
- Decode table:
  - R-type (opcode 0): funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll. Controls reg_dst=1, alu_src=0, reg_wr=1. Any other funct -> HALT.
  - addi 001000: alu_src=1, ext_op=1, ADD, reg_wr.
  - ori 001101: alu_src=1, ext_op=0, OR, reg_wr.
  - lw 100011: alu_src=1, ext_op=1, ADD, mem_to_reg=1, reg_wr.
  - sw 101011: alu_src=1, ext_op=1, ADD, mem_wr.
  - beq 000100 and bne 000101: SUB, alu_src=0, no writes.
  - j 000010: no writes.
- Arithmetic: all PC arithmetic is 32-bit modulo. pc 32'hFFFF_FFFC + 4 wraps to 0.
- rt as a write target of 0: the sequencer still asserts reg_wr. Register-0 protection is the register file's responsibility.

Optional Feature:
- Macro: DATAPATH_SEQ_OVF_TRAP_EN.
- Defined:
  - During EXEC of add, sub or addi, ovflw=1 forces reg_wr=0. This is combinational on ovflw.
  - PC is not updated, and the next state is HALT with halted=1.
- Undefined: ovflw is ignored and the result is written normally.

Test Plan:
- Reset, then rst=0 with imem_ack tied 1 -> imem_req=1, imem_addr=0; after 3 cycles pc=4.
- Fetch of 0x2008_0005 (addi $8,$0,5) -> in EXEC: rs=0, rt=8, imm=5, alu_src=1, ext_op=1, alu_ctrl=000, reg_dst=0, reg_wr=1 for exactly one cycle.
- sw 0xAC08_0010 -> mem_wr=1 and reg_wr=0 in EXEC only. lw 0x8C09_0010 -> mem_to_reg=1, reg_wr=1.
- beq with imm=16'hFFFF at pc=8: zero=1 -> pc=8; zero=0 -> pc=12.
- imem_ack delayed 4 cycles -> imem_addr stable and imem_req high throughout. rst pulsed during EXEC -> no write pulse completes, pc=RESET_PC.
- Instruction 0xFC00_0000 -> halted=1 and imem_req=0 indefinitely. With DATAPATH_SEQ_OVF_TRAP_EN, add with ovflw=1 -> reg_wr=0, then halted=1.
